// File: rtl/current_sense_pkg.sv
// Shared types and constants for the motor-current ADC front end.
package current_sense_pkg;

  // Data widths
  localparam int ADC_W = 12;   // unsigned ADC code
  localparam int CUR_W = 13;   // signed current word

  // Default timing (32 MHz system clock)
  localparam int DEF_CLK_DIV       = 8;     // CLK cycles per SCLK half-period
  localparam int DEF_FRAME_BITS    = 16;    // SCLK cycles per frame
  localparam int DEF_LEAD_BITS     = 4;     // leading bits that must read 0
  localparam int DEF_DATA_BITS     = 12;    // result bits after the leading bits
  localparam int DEF_SAMPLE_PERIOD = 3200;  // CLK cycles between frame starts
  localparam int DEF_AVG_LOG2      = 3;     // log2 of block-average length

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } frame_state_t;

endpackage

// File: rtl/adc_spi_frame.sv
// One SPI conversion frame: CS setup, FRAME_BITS SCLK periods (idle high),
// MSB-first shift register. o_done is a one-cycle strobe on the last cycle
// of the final high phase, so the caller can register results into the
// same cycle that cs_n returns high.
module adc_spi_frame
  import current_sense_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_miso,
  output logic                  o_cs_n,
  output logic                  o_sclk,
  output logic                  o_done,
  output logic [FRAME_BITS-1:0] o_frame
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  frame_state_t          r_state, w_state_nxt;
  logic [DIV_W-1:0]      r_div, w_div_nxt;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic                  r_cs_n, w_cs_n_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  w_div_end;
  logic                  w_sample;
  logic                  w_done;

  assign w_div_end = (r_div == DIV_LAST);
  // The edge that ends a low phase is the edge where sclk rises: capture there.
  assign w_sample  = (r_state == ST_SHIFT) && !r_sclk && w_div_end;
  assign w_done    = (r_state == ST_SHIFT) && r_sclk && w_div_end && (r_bit == BIT_LAST);

  // State, counters and pin flops; reset forces the bus idle immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sclk  <= w_sclk_nxt;
    end
  end

  // MSB-first shift register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_shift <= '0;
    else if (w_sample) r_shift <= {r_shift[FRAME_BITS-2:0], i_miso};
  end

  // Next-state and next pin values.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_cs_n_nxt  = r_cs_n;
    w_sclk_nxt  = r_sclk;
    case (r_state)
      ST_IDLE: begin
        w_cs_n_nxt = 1'b1;
        w_sclk_nxt = 1'b1;
        w_div_nxt  = '0;
        w_bit_nxt  = '0;
        if (i_start) begin
          w_state_nxt = ST_SETUP;
          w_cs_n_nxt  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (w_div_end) begin
          w_state_nxt = ST_SHIFT;
          w_div_nxt   = '0;
          w_sclk_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!w_div_end) begin
          w_div_nxt = r_div + 1'b1;
        end else begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_DONE;
            w_cs_n_nxt  = 1'b1;
          end else begin
            w_bit_nxt  = r_bit + 1'b1;
            w_sclk_nxt = 1'b0;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_cs_n  = r_cs_n;
  assign o_sclk  = r_sclk;
  assign o_done  = w_done;
  assign o_frame = r_shift;

endmodule

// File: rtl/current_sense_adc.sv
// Periodic SPI master for the motor-current ADC. Starts a frame every
// SAMPLE_PERIOD cycles while enabled, rejects frames whose leading bits are
// non-zero, and reports raw - offset as a signed current word.
// Build option: define CURRENT_AVG_EN to report a block average of
// 2^AVG_LOG2 good frames instead of every frame.
module current_sense_adc
  import current_sense_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int FRAME_BITS    = DEF_FRAME_BITS,
  parameter int LEAD_BITS     = DEF_LEAD_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
`ifdef CURRENT_AVG_EN
  , parameter int AVG_LOG2    = DEF_AVG_LOG2
`endif
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    enable,
  input  logic        [ADC_W-1:0] offset,
  output logic                    cs_n,
  output logic                    sclk,
  input  logic                    miso,
  output logic        [ADC_W-1:0] raw,
  output logic signed [CUR_W-1:0] current,
  output logic                    current_valid,
  output logic                    frame_error
);

  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  logic [TMR_W-1:0]        r_timer;
  logic                    w_tick;
  logic                    w_done;
  logic [FRAME_BITS-1:0]   w_frame;
  logic [LEAD_BITS-1:0]    w_lead;
  logic [ADC_W-1:0]        w_data;
  logic                    w_good;
  logic                    w_bad;
  logic signed [CUR_W-1:0] w_diff;
  logic [ADC_W-1:0]        r_raw;
  logic signed [CUR_W-1:0] r_current;
  logic                    r_valid;
  logic                    r_error;

  // The frame starts on the edge where the timer wraps back to 0, so the
  // first frame after enable/reset comes one full period later. Ticks that
  // land while a frame is in flight are ignored by the sequencer.
  assign w_tick = enable && (r_timer == TMR_LAST);

  // Period timer: free-running while enabled, parked at 0 otherwise.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)        r_timer <= '0;
    else if (!enable) r_timer <= '0;
    else if (w_tick)  r_timer <= '0;
    else              r_timer <= r_timer + 1'b1;
  end

  adc_spi_frame #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_frame (
    .CLK     (CLK),
    .reset   (reset),
    .i_start (w_tick),
    .i_miso  (miso),
    .o_cs_n  (cs_n),
    .o_sclk  (sclk),
    .o_done  (w_done),
    .o_frame (w_frame)
  );

  assign w_lead = w_frame[FRAME_BITS-1 -: LEAD_BITS];
  assign w_data = w_frame[DATA_BITS-1:0];
  assign w_good = w_done && (w_lead == '0);
  assign w_bad  = w_done && (w_lead != '0);
  // Both operands zero-extended to 13 bits: range -4095..+4095, no overflow.
  assign w_diff = $signed({1'b0, w_data}) - $signed({1'b0, offset});

  // Raw code and frame-error strobe; a bad frame leaves raw untouched.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_raw   <= '0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_bad;
      if (w_good) r_raw <= w_data;
    end
  end

`ifdef CURRENT_AVG_EN
  localparam int SUM_W = CUR_W + AVG_LOG2;

  logic signed [SUM_W-1:0] r_sum;
  logic signed [SUM_W-1:0] w_sum_nxt;
  logic [AVG_LOG2-1:0]     r_cnt;

  assign w_sum_nxt = r_sum + $signed({{AVG_LOG2{w_diff[CUR_W-1]}}, w_diff});

  // Block averager: on the last good frame of a block, publish the floor
  // of the mean and restart. Disabling discards the partial block.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_sum     <= '0;
      r_cnt     <= '0;
      r_current <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        r_sum <= '0;
        r_cnt <= '0;
      end else if (w_good) begin
        if (r_cnt == '1) begin
          r_current <= CUR_W'(w_sum_nxt >>> AVG_LOG2);
          r_valid   <= 1'b1;
          r_sum     <= '0;
          r_cnt     <= '0;
        end else begin
          r_sum <= w_sum_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
`else
  // Every good frame publishes its difference directly.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_current <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_good;
      if (w_good) r_current <= w_diff;
    end
  end
`endif

  assign raw           = r_raw;
  assign current       = r_current;
  assign current_valid = r_valid;
  assign frame_error   = r_error;

endmodule

// File: tb/tb_current_sense_adc.sv
// Self-checking bench for current_sense_adc: SPI ADC model, per-cycle
// reference model of pins and results, directed and randomized frames.
`timescale 1ns/1ps
module tb_current_sense_adc;

  localparam int P      = 800;                  // shortened sample period
  localparam int CDIV   = 8;
  localparam int FBITS  = 16;
  localparam int LAST_K = CDIV + 2*CDIV*FBITS;  // last cycle with cs_n low (264)

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] offset = '0;
  logic        miso = 1'b1;
  logic        cs_n, sclk, current_valid, frame_error;
  logic [11:0] raw;
  logic signed [12:0] current;

  logic [15:0] cur_word = '0;   // word the ADC will return in the next frame
  int tcyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_valid = 0;

  current_sense_adc #(.SAMPLE_PERIOD(P)) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .offset(offset),
    .cs_n(cs_n), .sclk(sclk), .miso(miso), .raw(raw), .current(current),
    .current_valid(current_valid), .frame_error(frame_error)
  );

  always #15.625 CLK = ~CLK;
  always @(posedge CLK) tcyc <= tcyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- ADC model (SPI mode 3, MSB ready at cs_n fall) ----------
  logic [15:0] a_word = '0;
  int a_idx = 15, a_falls = 0;
  logic a_prev = 1'b1;
  always @(negedge CLK) begin
    if (cs_n) begin
      a_word = cur_word; a_idx = 15; a_falls = 0; a_prev = 1'b1;
    end else begin
      if (a_prev && !sclk) begin
        if (a_falls > 0) a_idx--;
        a_falls++;
      end
      a_prev = sclk;
    end
    miso = a_word[a_idx];
  end

  // ---------------- Reference model + per-cycle compare ----------------------
  function automatic int exp_sclk(input int k);
    if (k >= CDIV + 1 && k <= LAST_K) return (((k - CDIV - 1) / CDIV) % 2 == 0) ? 0 : 1;
    return 1;
  endfunction

  function automatic int floor_div(input int s, input int d);
    return (s >= 0) ? s / d : -((-s + d - 1) / d);
  endfunction

  int m_run = 0, m_fs = 0, m_k = 0, m_raw = 0, m_cur = 0, m_diff = 0;
  bit m_act = 0, e_valid = 0, e_err = 0;
  logic [15:0] m_word = '0;
  int m_sum[$];

  always @(negedge CLK) begin
    if (reset) begin
      check("rst_cs_n", cs_n, 1); check("rst_sclk", sclk, 1);
      check("rst_valid", current_valid, 0); check("rst_err", frame_error, 0);
      check("rst_raw", raw, 0); check("rst_cur", $signed(current), 0);
      m_run = 0; m_act = 0; m_raw = 0; m_cur = 0; e_valid = 0; e_err = 0;
      m_sum.delete();
    end else begin
      m_k = m_act ? tcyc - m_fs : 0;
      check("cs_n", cs_n, (m_act && m_k >= 1 && m_k <= LAST_K) ? 0 : 1);
      check("sclk", sclk, exp_sclk(m_k));
      check("valid", current_valid, e_valid);
      check("frame_error", frame_error, e_err);
      check("raw", raw, m_raw);
      check("current", $signed(current), m_cur);
      if (current_valid) n_valid++;
      // effects of the coming clock edge
      e_valid = 0; e_err = 0;
      if (m_act && m_k == LAST_K) begin
        if (m_word[15:12] != 0) e_err = 1;
        else begin
          m_raw  = m_word[11:0];
          m_diff = int'(m_word[11:0]) - int'(offset);
`ifdef CURRENT_AVG_EN
          if (enable) begin
            m_sum.push_back(m_diff);
            if (m_sum.size() == 8) begin
              m_cur = floor_div(m_sum.sum(), 8); e_valid = 1; m_sum.delete();
            end
          end
`else
          m_cur = m_diff; e_valid = 1;
`endif
        end
      end
`ifdef CURRENT_AVG_EN
      if (!enable) m_sum.delete();
`endif
      if (enable && (m_run % P) == P - 1 && !m_act) begin
        m_act = 1; m_fs = tcyc; m_word = cur_word;
      end else if (m_act && m_k == LAST_K + 1) begin
        m_act = 0;
      end
      m_run = enable ? m_run + 1 : 0;
    end
  end

  // ---------------- Stimulus helpers -----------------------------------------
  task automatic wait_lvl(input bit use_sclk, input logic lvl, input int max_cyc, input string tag);
    int n = 0;
    while ((use_sclk ? sclk : cs_n) !== lvl && n < max_cyc) begin
      @(negedge CLK); n++;
    end
    if ((use_sclk ? sclk : cs_n) !== lvl) begin
      n_checks++;
      $display("FAIL %s: timeout after %0d cycles, level %b never seen", tag, n, lvl);
    end
  endtask

  task automatic drive_frame(input logic [15:0] w, input logic [11:0] ofs);
    @(posedge CLK); #2; cur_word = w; offset = ofs;
    wait_lvl(0, 0, 2*P, "frame_start");
    wait_lvl(0, 1, 400, "frame_end");
  endtask

  int t_fall, t_end, lows, n0, nwait;
  realtime t1, t2;
  int avg_diff[8] = '{10, 11, 12, 13, -1, -2, -3, -4};

  initial begin
    repeat (5) @(posedge CLK);
    #2 reset = 0;
    @(negedge CLK);
    check("post_rst_cs_n", cs_n, 1); check("post_rst_raw", raw, 0);
    check("post_rst_cur", $signed(current), 0);

    // 1: code 2560, offset 2048 -> +512, latency and SCLK period
    @(posedge CLK); #2; cur_word = 16'h0A00; offset = 12'd2048; enable = 1;
    wait_lvl(0, 0, 2*P, "t1_start");
    t_fall = tcyc;
    wait_lvl(1, 0, 40, "t1_sclk_lo"); wait_lvl(1, 1, 40, "t1_sclk_hi"); t1 = $realtime;
    wait_lvl(1, 0, 40, "t1_sclk_lo2"); wait_lvl(1, 1, 40, "t1_sclk_hi2"); t2 = $realtime;
    check("sclk_period_ns", int'(t2 - t1), 500);
    wait_lvl(0, 1, 400, "t1_end");
    t_end = tcyc;
    check("latency", t_end - (t_fall - 1), 265);
    check("t1_raw", raw, 2560);
`ifndef CURRENT_AVG_EN
    check("t1_valid", current_valid, 1);
    check("t1_current", $signed(current), 512);
`endif

    // 2: bounds
    drive_frame(16'h0000, 12'd4095);
    check("t2a_raw", raw, 0);
`ifndef CURRENT_AVG_EN
    check("t2a_current", $signed(current), -4095);
`endif
    drive_frame(16'h0FFF, 12'd0);
    check("t2b_raw", raw, 4095);
`ifndef CURRENT_AVG_EN
    check("t2b_current", $signed(current), 4095);
`endif

    // 3: leading bit set -> error, results hold
    drive_frame(16'h8123, 12'd1000);
    check("t3_err", frame_error, 1);
    check("t3_valid", current_valid, 0);
    check("t3_raw", raw, 4095);
`ifndef CURRENT_AVG_EN
    check("t3_current", $signed(current), 4095);
`endif

    // randomized frames, with an offset change somewhere inside each frame
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #2;
      cur_word = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {4'h0, 12'($urandom)};
      offset = 12'($urandom);
      wait_lvl(0, 0, 2*P, "rnd_start");
      nwait = $urandom_range(1, 250);
      repeat (nwait) @(negedge CLK);
      @(posedge CLK); #2; offset = 12'($urandom);
      wait_lvl(0, 1, 400, "rnd_end");
    end

    // 4: enable dropped at the 5th SCLK rise; frame completes, nothing after
    @(posedge CLK); #2; cur_word = 16'h0123; offset = 12'd300;
    wait_lvl(0, 0, 2*P, "t4_start");
    for (int r = 0; r < 5; r++) begin
      wait_lvl(1, 0, 40, "t4_lo"); wait_lvl(1, 1, 40, "t4_hi");
    end
    @(posedge CLK); #2; enable = 0;
    wait_lvl(0, 1, 400, "t4_end");
`ifndef CURRENT_AVG_EN
    check("t4_valid", current_valid, 1);
    check("t4_current", $signed(current), 291 - 300);
`endif
    lows = 0;
    repeat (2*P) begin @(negedge CLK); if (!cs_n) lows++; end
    check("t4_no_new_frame", lows, 0);

    // 5: reset mid-SHIFT, then restart exactly one period after release
    @(posedge CLK); #2; enable = 1;
    wait_lvl(0, 0, 2*P, "t5_start");
    repeat (100) @(negedge CLK);
    @(posedge CLK); #2; reset = 1;
    #1;
    check("t5_cs_n", cs_n, 1); check("t5_sclk", sclk, 1);
    check("t5_raw", raw, 0); check("t5_cur", $signed(current), 0);
    check("t5_valid", current_valid, 0);
    cur_word = {4'h0, 12'(100 + avg_diff[0])}; offset = 12'd100;
    repeat (3) @(posedge CLK);
    #2 reset = 0;
    n0 = 0;
    while (cs_n && n0 < 2*P) begin @(negedge CLK); if (cs_n) n0++; end
    check("t5_restart_cycles", n0, P);

    // 6: block of eight diffs {10..13,-1..-4}; frame 0 is already running
    n0 = n_valid;
    for (int i = 0; i < 8; i++) begin
      wait_lvl(0, 1, 400, "t6_end");
      if (i < 7) begin
        @(posedge CLK); #2; cur_word = {4'h0, 12'(100 + avg_diff[i+1])};
        wait_lvl(0, 0, 2*P, "t6_start");
      end
    end
    @(negedge CLK);
`ifdef CURRENT_AVG_EN
    check("t6_valid_count", n_valid - n0, 1);
    check("t6_avg", $signed(current), 4);
`else
    check("t6_valid_count", n_valid - n0, 8);
    check("t6_last", $signed(current), -4);
`endif
    check("t6_raw", raw, 96);

    repeat (5) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
